// File: rtl/left_funnel_shifter_seq.sv
// Multi-cycle left funnel shifter: y = ({in1,in2} << amt) upper half, one step per clock,
// behind valid/ready handshakes. Define FUNNEL_DOUBLE_STEP_EN to shift two bits per edge while cnt>=2.
module left_funnel_shifter_seq #(
  parameter int WIDTH = 10,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [AMT_W-1:0] amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2*WIDTH-1:0]   r_sr;
  logic [2*WIDTH-1:0]   w_sr_nxt;
  logic [AMT_W-1:0]     r_cnt;
  logic [AMT_W-1:0]     w_cnt_nxt;
  logic [AMT_W-1:0]     w_step;

`ifdef FUNNEL_DOUBLE_STEP_EN
  assign w_step = (r_cnt > AMT_W'(1)) ? AMT_W'(2) : AMT_W'(1);
`else
  assign w_step = AMT_W'(1);
`endif

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    in_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_sr_nxt    = {in1, in2};
          w_cnt_nxt   = amt;
          w_state_nxt = (amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        w_sr_nxt  = r_sr << w_step;
        w_cnt_nxt = r_cnt - w_step;
        if (r_cnt == w_step) w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sr    <= w_sr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The shift register is frozen in DONE, so its upper half is the registered result.
  assign out_valid = (r_state == DONE);
  assign y         = r_sr[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_left_funnel_shifter_seq.sv
// Self-checking bench for left_funnel_shifter_seq: vector table, random ops with a
// reference model, and hand-written DONE-hold and mid-shift reset sequences.
module tb_left_funnel_shifter_seq;

  localparam int W  = 10;
  localparam int AW = 4;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  in1       = '0;
  logic [W-1:0]  in2       = '0;
  logic [AW-1:0] amt       = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  y;

  left_funnel_shifter_seq #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .amt       (amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  in1;
    logic [W-1:0]  in2;
    logic [AW-1:0] amt;
    logic [W-1:0]  exp_y;
  } vec_t;

  vec_t         vecs[10];
  logic [W-1:0] sb_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [AW-1:0] s);
    logic [2*W-1:0] t;
    t = {a, b} << s;
    return t[2*W-1:W];
  endfunction

  function automatic int exp_lat(input int s);
`ifdef FUNNEL_DOUBLE_STEP_EN
    return (s + 1) / 2 + 1;
`else
    return s + 1;
`endif
  endfunction

  // Present one operation and leave just after its accept edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [AW-1:0] s, input logic [W-1:0] e);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", 32'(in_ready), 32'd1);
    in1 = a; in2 = b; amt = s; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb_q.push_back(e);
  endtask

  // Count edges from the accept edge until out_valid, then score y.
  task automatic wait_done(input int lat);
    int n = 1;
    bit ready_seen = 1'b0;
    while (!out_valid && n < 40) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    if (in_ready) ready_seen = 1'b1;
    check("out_valid_rise", 32'(out_valid), 32'd1);
    check("latency", 32'(n), 32'(lat));
    check("in_ready_low_busy", 32'(ready_seen), 32'd0);
    if (sb_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
    else check("y", 32'(y), 32'(sb_q.pop_front()));
  endtask

  task automatic finish_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_after_hs", 32'(out_valid), 32'd0);
    check("in_ready_after_hs", 32'(in_ready), 32'd1);
  endtask

  task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] s, input logic [W-1:0] e);
    start_op(a, b, s, e);
    wait_done(exp_lat(int'(s)));
    finish_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]  ra, rb, held;
    logic [AW-1:0] rs;

    vecs[0] = '{10'h001, 10'h002, 4'd1,  10'h002};
    vecs[1] = '{10'h201, 10'h201, 4'd2,  10'h006};
    vecs[2] = '{10'h201, 10'h201, 4'd1,  10'h003};
    vecs[3] = '{10'h2AA, 10'h123, 4'd0,  10'h2AA};
    vecs[4] = '{10'h3FF, 10'h155, 4'd10, 10'h155};
    vecs[5] = '{10'h000, 10'h3FF, 4'd15, 10'h3E0};
    vecs[6] = '{10'h3FF, 10'h000, 4'd4,  10'h3F0};
    vecs[7] = '{10'h0F0, 10'h3C0, 4'd3,  10'h387};
    vecs[8] = '{10'h155, 10'h2AB, 4'd12, 10'h2AC};
    vecs[9] = '{10'h2AA, 10'h155, 4'd9,  10'h0AA};

    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++)
      run_vec(vecs[i].in1, vecs[i].in2, vecs[i].amt, vecs[i].exp_y);

    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = AW'($urandom_range(0, 15));
      run_vec(ra, rb, rs, model(ra, rb, rs));
    end

    // DONE held with out_ready low; in_valid pulses must be ignored.
    start_op(10'h0F0, 10'h3C0, 4'd3, 10'h387);
    wait_done(exp_lat(3));
    held = 10'h387;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in1 = 10'h3FF; in2 = 10'h000; amt = 4'd0; in_valid = (i % 2 == 0);
      @(posedge clk);
      #1;
      check("hold_y", 32'(y), 32'(held));
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    finish_out();
    @(posedge clk);
    #1;
    check("no_stray_accept", 32'(out_valid), 32'd0);

    // Reset mid-SHIFT: accept edge plus two more edges, then async reset between edges.
    start_op(10'h0AB, 10'h155, 4'd8, model(10'h0AB, 10'h155, 4'd8));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_y", 32'(y), 32'd0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(10'h0AB, 10'h155, 4'd8, 10'h355);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
